// File: rtl/digit_dec_ctrl.sv
// digit_dec_ctrl: buffers serial FC class sums, fires the argmax stage and returns its verdict on valid/ready.
// Optional watchdog on the WAIT state is enabled with `define DIGIT_CTRL_WDOG_EN.
module digit_dec_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int N_MATS      = 10,
  parameter int WDOG_CYCLES = 32,
  localparam int IDX_W      = $clog2(N_MATS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             s_sum,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [N_MATS-1:0][DATA_WIDTH-1:0] dec_sum,
  output logic                              dec_valid_in,
  input  logic [DATA_WIDTH-1:0]             dec_max,
  input  logic [IDX_W-1:0]                  dec_index,
  input  logic                              dec_valid_out,
  output logic [IDX_W-1:0]                  m_digit,
  output logic [DATA_WIDTH-1:0]             m_max,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              busy,
  output logic                              err_len,
  output logic                              err_timeout,
  output logic [15:0]                       frame_cnt
);

  typedef enum logic [1:0] {COLLECT, FIRE, WAIT, HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        m_digit_reg;
  logic [DATA_WIDTH-1:0]   m_max_reg;
  logic [15:0]             frame_cnt_reg;
  logic                    err_len_reg;
  logic                    beat_acc;
  logic                    last_beat;
  logic                    len_err;
  logic                    wdog_expire;

  assign s_ready      = (state_reg == COLLECT);
  assign dec_valid_in = (state_reg == FIRE);
  assign m_valid      = (state_reg == HOLD);
  assign busy         = (state_reg != COLLECT) || (cnt_reg != '0);
  assign beat_acc     = s_valid & s_ready;
  assign last_beat    = (cnt_reg == IDX_W'(N_MATS - 1));
  // Length error: s_last before the final class, or missing on the final class.
  assign len_err      = beat_acc & (last_beat ? ~s_last : s_last);

  assign m_digit   = m_digit_reg;
  assign m_max     = m_max_reg;
  assign err_len   = err_len_reg;
  assign frame_cnt = frame_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_MATS; gi++) begin : g_buf
      logic [DATA_WIDTH-1:0] sum_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_reg <= '0;
        end else if (beat_acc && (cnt_reg == IDX_W'(gi))) begin
          sum_reg <= s_sum;
        end
      end
      assign dec_sum[gi] = sum_reg;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      COLLECT: begin
        if (beat_acc) begin
          if (last_beat) begin
            cnt_next   = '0;
            state_next = FIRE;
          end else if (s_last) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + IDX_W'(1);
          end
        end
      end
      FIRE: state_next = WAIT;
      WAIT: begin
        if (dec_valid_out) begin
          state_next = HOLD;
        end else if (wdog_expire) begin
          state_next = COLLECT;
        end
      end
      HOLD: begin
        if (m_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      m_digit_reg   <= '0;
      m_max_reg     <= '0;
      frame_cnt_reg <= '0;
      err_len_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      err_len_reg <= len_err;
      if ((state_reg == WAIT) && dec_valid_out) begin
        m_digit_reg <= dec_index;
        m_max_reg   <= dec_max;
      end
      if ((state_reg == HOLD) && m_ready) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

`ifdef DIGIT_CTRL_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_reg;
  logic              err_timeout_reg;

  // A result arriving on the last allowed cycle still wins over the timeout.
  assign wdog_expire = (state_reg == WAIT) && !dec_valid_out &&
                       (wdog_reg == WDOG_W'(WDOG_CYCLES - 1));
  assign err_timeout = err_timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_reg        <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      wdog_reg        <= (state_reg == WAIT) ? wdog_reg + WDOG_W'(1) : '0;
      err_timeout_reg <= wdog_expire;
    end
  end
`else
  assign wdog_expire = 1'b0;
  // Watchdog compiled out; the parameter stays referenced so both builds share one interface.
  assign err_timeout = 1'b0 & (WDOG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_digit_dec_ctrl.sv
// Self-checking bench for digit_dec_ctrl: behavioural argmax stub plus directed and randomized frames.
// Watchdog scenario runs only when DIGIT_CTRL_WDOG_EN is defined.
module tb_digit_dec_ctrl;
  localparam int DW  = 16;
  localparam int NM  = 10;
  localparam int IW  = 4;
  localparam int LAT = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DW-1:0]         s_sum;
  logic                  s_valid, s_last, s_ready;
  logic [NM-1:0][DW-1:0] dec_sum;
  logic                  dec_valid_in;
  logic [DW-1:0]         dec_max = '0;
  logic [IW-1:0]         dec_index = '0;
  logic                  dec_valid_out = 1'b0;
  logic [IW-1:0]         m_digit;
  logic [DW-1:0]         m_max;
  logic                  m_valid, m_ready, busy, err_len, err_timeout;
  logic [15:0]           frame_cnt;

  int tests = 0;
  int fails = 0;
  int exp_fc = 0;
  logic [DW-1:0] frame [NM];

  always #5 clk = ~clk;

  digit_dec_ctrl #(.DATA_WIDTH(DW), .N_MATS(NM), .WDOG_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .s_sum(s_sum), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .dec_sum(dec_sum), .dec_valid_in(dec_valid_in), .dec_max(dec_max), .dec_index(dec_index),
    .dec_valid_out(dec_valid_out), .m_digit(m_digit), .m_max(m_max), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .err_len(err_len), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  // Behavioural digit_dec: answers stub_lat cycles after the fire pulse.
  int            stub_lat = LAT;
  bit            stub_never = 1'b0;
  bit            stub_force = 1'b0;
  int            stub_cnt = 0;
  bit            stub_pend = 1'b0;
  logic [DW-1:0] stub_max;
  logic [IW-1:0] stub_idx;

  always @(negedge clk) begin
    dec_valid_out = stub_force;
    if (stub_pend) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        dec_valid_out = 1'b1;
        dec_max       = stub_max;
        dec_index     = stub_idx;
        stub_pend     = 1'b0;
      end
    end
    if (dec_valid_in === 1'b1 && !stub_never) begin
      stub_pend = 1'b1;
      stub_cnt  = stub_lat;
      stub_idx  = '0;
      stub_max  = dec_sum[0];
      for (int k = 1; k < NM; k++) begin
        if (dec_sum[k] > stub_max) begin
          stub_max = dec_sum[k];
          stub_idx = IW'(k);
        end
      end
    end
  end

  // Pulse monitor: sees the values of the cycle ending at each edge.
  int   err_len_pulses = 0;
  int   err_len_long = 0;
  int   fire_pulses = 0;
  int   timeout_pulses = 0;
  logic err_len_prev = 1'b0;

  always @(posedge clk) begin
    if (err_len === 1'b1) err_len_pulses++;
    if (err_len === 1'b1 && err_len_prev === 1'b1) err_len_long++;
    err_len_prev = err_len;
    if (dec_valid_in === 1'b1) fire_pulses++;
    if (err_timeout === 1'b1) timeout_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  function automatic logic [DW-1:0] rand_fp16();
    return {1'b0, 5'($urandom_range(0, 30)), 10'($urandom)};
  endfunction

  // Reference: largest positive FP16 score, first occurrence wins a tie.
  task automatic model_argmax(output int idx, output logic [DW-1:0] mx);
    idx = 0;
    mx  = frame[0];
    for (int k = 1; k < NM; k++) begin
      if (frame[k] > mx) begin
        mx  = frame[k];
        idx = k;
      end
    end
  endtask

  // bubbles: 0 none, 1 every other cycle, 2 random. Returns at the negedge after the last beat.
  task automatic send_frame(input int n, input int last_pos, input int bubbles);
    int i = 0;
    int cyc = 0;
    bit gap;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      gap = (bubbles == 1) ? (cyc % 2 == 0) : (bubbles == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (gap) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_sum   = frame[i];
        s_last  = (i == last_pos);
        if (s_ready === 1'b1) i++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tests++;
    if (i < n) begin
      fails++;
      $display("FAIL send_frame: only %0d of %0d beats accepted", i, n);
    end
  endtask

  task automatic wait_result(input int budget, output int cycles);
    cycles = 0;
    while (m_valid !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_result: m_valid=%b after %0d cycles, required 1", m_valid, cycles);
    end
  endtask

  task automatic handshake(input string name);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    exp_fc++;
    tests++;
    if (frame_cnt !== 16'(exp_fc) || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_handshake: frame_cnt=%0d m_valid=%b s_ready=%b, required %0d/0/1",
               name, frame_cnt, m_valid, s_ready, exp_fc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_sum = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_s_ready: got %b, required 1", s_ready); end
    tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests++; if (dec_valid_in !== 1'b0) begin fails++; $display("FAIL reset_fire: got %b, required 0", dec_valid_in); end
    tests++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt); end
    tests++; if (err_len !== 1'b0 || err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err: got %b%b, required 00", err_len, err_timeout); end
    tests++; if (m_digit !== '0 || m_max !== '0) begin fails++; $display("FAIL reset_result: got %0d/%h, required 0/0000", m_digit, m_max); end
    tests++; if (dec_sum !== '0) begin fails++; $display("FAIL reset_buffer: got %h, required 0", dec_sum); end
    rst = 1'b0;
    exp_fc = 0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int cyc, f0;
    for (int k = 0; k < NM; k++) frame[k] = 16'h3C00;
    frame[7] = 16'h4200;
    f0 = fire_pulses;
    send_frame(10, 9, 0);
    tests++; if (dec_valid_in !== 1'b1) begin fails++; $display("FAIL nominal_fire_cycle: dec_valid_in=%b, required 1", dec_valid_in); end
    wait_result(40, cyc);
    tests++; if (cyc != LAT + 1) begin fails++; $display("FAIL nominal_latency: m_valid after %0d cycles, required %0d", cyc, LAT + 1); end
    tests++; if (m_digit !== 4'd7 || m_max !== 16'h4200) begin fails++; $display("FAIL nominal_result: got %0d/%h, required 7/4200", m_digit, m_max); end
    tests++; if (fire_pulses - f0 != 1) begin fails++; $display("FAIL nominal_fire_count: got %0d, required 1", fire_pulses - f0); end
    handshake("nominal");
  endtask

  task automatic test_tie_bubbles();
    int cyc, e0;
    for (int k = 0; k < NM; k++) frame[k] = 16'h3C00;
    frame[2] = 16'h4000;
    frame[5] = 16'h4000;
    e0 = err_len_pulses;
    send_frame(10, 9, 1);
    wait_result(40, cyc);
    tests++; if (m_digit !== 4'd2 || m_max !== 16'h4000) begin fails++; $display("FAIL tie_result: got %0d/%h, required 2/4000", m_digit, m_max); end
    handshake("tie");
    @(negedge clk);
    tests++; if (err_len_pulses != e0) begin fails++; $display("FAIL tie_err_len: got %0d pulses, required 0", err_len_pulses - e0); end
  endtask

  task automatic test_backpressure();
    int cyc, bad;
    for (int k = 0; k < NM; k++) frame[k] = 16'h3C00;
    frame[3] = 16'h4500;
    send_frame(10, 9, 0);
    wait_result(40, cyc);
    bad = 0;
    s_valid = 1'b1;
    s_sum   = 16'h4800;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_digit !== 4'd3 || m_max !== 16'h4500 || s_ready !== 1'b0 || m_valid !== 1'b1 ||
          frame_cnt !== 16'(exp_fc)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL backpressure_hold: %0d bad cycles (last %0d/%h s_ready=%b fc=%0d), required 3/4500 s_ready=0 fc=%0d",
               bad, m_digit, m_max, s_ready, frame_cnt, exp_fc);
    end
    s_valid = 1'b0;
    handshake("backpressure");
  endtask

  task automatic test_early_last();
    int cyc, f0;
    for (int k = 0; k < NM; k++) frame[k] = 16'h3C00;
    f0 = fire_pulses;
    send_frame(5, 4, 0);
    tests++; if (err_len !== 1'b1) begin fails++; $display("FAIL early_err_len: got %b, required 1", err_len); end
    @(negedge clk);
    tests++; if (err_len !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL early_recover: err_len=%b busy=%b, required 0/0", err_len, busy); end
    repeat (3) @(negedge clk);
    tests++; if (fire_pulses != f0) begin fails++; $display("FAIL early_no_fire: got %0d fires, required 0", fire_pulses - f0); end
    frame[0] = 16'h4200;
    send_frame(10, 9, 0);
    wait_result(40, cyc);
    tests++; if (m_digit !== 4'd0 || m_max !== 16'h4200) begin fails++; $display("FAIL early_next_result: got %0d/%h, required 0/4200", m_digit, m_max); end
    handshake("early");
  endtask

  task automatic test_missing_last();
    int cyc, ei;
    logic [DW-1:0] em;
    for (int k = 0; k < NM; k++) frame[k] = rand_fp16();
    model_argmax(ei, em);
    send_frame(10, -1, 0);
    tests++; if (err_len !== 1'b1 || dec_valid_in !== 1'b1) begin fails++; $display("FAIL missing_last_flags: err_len=%b fire=%b, required 1/1", err_len, dec_valid_in); end
    wait_result(40, cyc);
    tests++; if (m_digit !== IW'(ei) || m_max !== em) begin fails++; $display("FAIL missing_last_result: got %0d/%h, required %0d/%h", m_digit, m_max, ei, em); end
    handshake("missing_last");
  endtask

  task automatic test_spurious();
    int bad = 0;
    stub_force = 1'b1;
    @(negedge clk);
    stub_force = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL spurious_ignored: %0d cycles with m_valid/busy set, required 0", bad); end
  endtask

`ifndef DIGIT_CTRL_WDOG_EN
  task automatic test_long_latency();
    int cyc, ei;
    logic [DW-1:0] em;
    for (int k = 0; k < NM; k++) frame[k] = rand_fp16();
    model_argmax(ei, em);
    stub_lat = 50;
    send_frame(10, 9, 0);
    wait_result(100, cyc);
    tests++; if (cyc != 51) begin fails++; $display("FAIL long_latency: m_valid after %0d cycles, required 51", cyc); end
    tests++; if (m_digit !== IW'(ei) || m_max !== em) begin fails++; $display("FAIL long_result: got %0d/%h, required %0d/%h", m_digit, m_max, ei, em); end
    handshake("long");
    stub_lat = LAT;
  endtask
`else
  task automatic test_watchdog();
    int k = 0;
    for (int j = 0; j < NM; j++) frame[j] = 16'h3C00;
    stub_never = 1'b1;
    send_frame(10, 9, 0);
    while (err_timeout !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (m_valid === 1'b1) break;
    end
    tests++; if (k != 33 || err_timeout !== 1'b1) begin fails++; $display("FAIL wdog_timing: err_timeout=%b at %0d cycles after fire, required 1 at 33", err_timeout, k); end
    tests++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || frame_cnt !== 16'(exp_fc)) begin fails++; $display("FAIL wdog_state: s_ready=%b m_valid=%b fc=%0d, required 1/0/%0d", s_ready, m_valid, frame_cnt, exp_fc); end
    @(negedge clk);
    tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL wdog_pulse_width: got %b, required 0", err_timeout); end
    stub_never = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_wait();
    int bad = 0;
    for (int k = 0; k < NM; k++) frame[k] = rand_fp16();
    send_frame(10, 9, 0);
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_wait_busy_before: got %b, required 1", busy); end
    #1 rst = 1'b1;
    #1;
    tests++; if (m_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin fails++; $display("FAIL rst_wait_async: m_valid=%b busy=%b fc=%0d, required 0/0/0", m_valid, busy, frame_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_fc = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rst_wait_late_result: %0d cycles with m_valid/busy set, required 0", bad); end
  endtask

  task automatic test_random();
    int cyc, ei, bad;
    logic [DW-1:0] em;
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < NM; k++) frame[k] = rand_fp16();
      if ($urandom_range(0, 2) == 0) frame[$urandom_range(0, NM - 1)] = frame[$urandom_range(0, NM - 1)];
      model_argmax(ei, em);
      stub_lat = $urandom_range(1, 12);
      send_frame(10, 9, 2);
      wait_result(60, cyc);
      tests++;
      if (m_digit !== IW'(ei) || m_max !== em) begin
        fails++;
        $display("FAIL random_%0d_result: got %0d/%h, required %0d/%h", f, m_digit, m_max, ei, em);
      end
      bad = 0;
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        if (m_valid !== 1'b1 || m_digit !== IW'(ei) || m_max !== em) bad++;
      end
      tests++; if (bad != 0) begin fails++; $display("FAIL random_%0d_hold: %0d unstable cycles, required 0", f, bad); end
      handshake("random");
    end
    stub_lat = LAT;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tie_bubbles();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_spurious();
`ifndef DIGIT_CTRL_WDOG_EN
    test_long_latency();
`else
    test_watchdog();
`endif
    test_reset_mid_wait();
    test_random();
    @(negedge clk);
    tests++; if (err_len_long != 0) begin fails++; $display("FAIL err_len_width: %0d multi-cycle pulses, required 0", err_len_long); end
`ifdef DIGIT_CTRL_WDOG_EN
    tests++; if (timeout_pulses != 1) begin fails++; $display("FAIL timeout_count: got %0d, required 1", timeout_pulses); end
`else
    tests++; if (timeout_pulses != 0) begin fails++; $display("FAIL timeout_count: got %0d, required 0", timeout_pulses); end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
